// File: rtl/sprite_broadcaster_if.sv
// rtl/sprite_broadcaster_if.sv - descriptor RAM, texture RAM and broadcast bus signals
interface sprite_broadcaster_if #(
   parameter int DESC_AW = 4
);
   logic               i_start;
   logic [DESC_AW:0]   i_sprite_count;
   logic               o_desc_rd;
   logic [DESC_AW-1:0] o_desc_addr;
   logic [24:0]        i_desc_data;
   logic               o_tex_rd;
   logic [11:0]        o_tex_addr;
   logic [127:0]       i_tex_data;
   logic               o_ena;
   logic [127:0]       o_texture_data;
   logic [4:0]         o_start_x;
   logic [7:0]         o_position_z;
   logic [3:0]         o_row;
   logic               o_busy;
   logic               o_done;

   modport master (
      input  i_start, i_sprite_count, i_desc_data, i_tex_data,
      output o_desc_rd, o_desc_addr, o_tex_rd, o_tex_addr,
      output o_ena, o_texture_data, o_start_x, o_position_z, o_row, o_busy, o_done
   );

   modport slave (
      output i_start, i_sprite_count, i_desc_data, i_tex_data,
      input  o_desc_rd, o_desc_addr, o_tex_rd, o_tex_addr,
      input  o_ena, o_texture_data, o_start_x, o_position_z, o_row, o_busy, o_done
   );
endinterface

// File: rtl/sprite_broadcaster.sv
// rtl/sprite_broadcaster.sv - walks the sprite list and broadcasts texture rows
module sprite_broadcaster #(
   parameter int NUM_ROWS = 16,
   parameter int DESC_AW  = 4
) (
   input logic                  clk,
   input logic                  reset,
   sprite_broadcaster_if.master bus
);
   typedef enum logic [2:0] {IDLE, DESC_RD, DESC_LAT, ROW_RD, ROW_EMIT, DONE} state_t;

   localparam logic [DESC_AW:0] MAX_SPRITES = (DESC_AW+1)'(2**DESC_AW);
   localparam logic [DESC_AW:0] ONE         = (DESC_AW+1)'(1);
   localparam logic [5:0]       ROW_LIMIT   = 6'(NUM_ROWS);

   state_t           state, next_state;
   logic [DESC_AW:0] idx, count, count_sat;
   logic [3:0]       r, y;
   logic [7:0]       z, base;
   logic [4:0]       x;
   logic [4:0]       row_sum;
   logic             row_visible, more_sprites;

   assign count_sat    = (bus.i_sprite_count > MAX_SPRITES) ? MAX_SPRITES : bus.i_sprite_count;
   assign row_sum      = {1'b0, y} + {1'b0, r};
   // Tall sprites are clipped rather than wrapped into row 0.
   assign row_visible  = ({1'b0, row_sum} < ROW_LIMIT);
   assign more_sprites = ((idx + ONE) < count);

   assign bus.o_desc_rd   = (state == DESC_RD);
   assign bus.o_desc_addr = idx[DESC_AW-1:0];
   assign bus.o_tex_rd    = (state == ROW_RD);
   assign bus.o_tex_addr  = {base, r};

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (bus.i_start) next_state = (count_sat == '0) ? DONE : DESC_RD;
         DESC_RD:  next_state = DESC_LAT;
         DESC_LAT: next_state = ROW_RD;
         ROW_RD:   next_state = ROW_EMIT;
         ROW_EMIT: begin
            if (r != 4'hF)        next_state = ROW_RD;
            else if (more_sprites) next_state = DESC_RD;
            else                   next_state = DONE;
         end
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         idx                <= '0;
         count              <= '0;
         r                  <= '0;
         y                  <= '0;
         z                  <= '0;
         x                  <= '0;
         base               <= '0;
         bus.o_ena          <= 1'b0;
         bus.o_texture_data <= '0;
         bus.o_start_x      <= '0;
         bus.o_position_z   <= '0;
         bus.o_row          <= '0;
         bus.o_busy         <= 1'b0;
         bus.o_done         <= 1'b0;
      end else begin
         state      <= next_state;
         bus.o_ena  <= 1'b0;
         bus.o_done <= (next_state == DONE);
         bus.o_busy <= (next_state != IDLE);
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  idx   <= '0;
                  count <= count_sat;
               end
            end
            DESC_LAT: begin
               z    <= bus.i_desc_data[24:17];
               x    <= bus.i_desc_data[16:12];
               y    <= bus.i_desc_data[11:8];
               base <= bus.i_desc_data[7:0];
               r    <= '0;
            end
            ROW_EMIT: begin
               // Bus data only moves on a visible row so it holds whenever o_ena is low.
               if (row_visible) begin
                  bus.o_ena          <= 1'b1;
                  bus.o_texture_data <= bus.i_tex_data;
                  bus.o_start_x      <= x;
                  bus.o_position_z   <= z;
                  bus.o_row          <= row_sum[3:0];
               end
               if (r != 4'hF)         r   <= r + 4'd1;
               else if (more_sprites) idx <= idx + ONE;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sprite_broadcaster.sv
// tb/tb_sprite_broadcaster.sv - directed self-checking bench for sprite_broadcaster
module tb_sprite_broadcaster;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sprite_broadcaster_if #(.DESC_AW(4)) bus ();
   sprite_broadcaster #(.NUM_ROWS(16), .DESC_AW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

   logic [24:0]  desc_mem [0:15];
   logic [127:0] tex_mem  [0:4095];

   always @(posedge clk) begin
      if (bus.o_desc_rd) bus.i_desc_data <= desc_mem[bus.o_desc_addr];
      if (bus.o_tex_rd)  bus.i_tex_data  <= tex_mem[bus.o_tex_addr];
   end

   int total = 0;
   int bad   = 0;

   int           ena_cyc [$];
   logic [3:0]   ena_row [$];
   logic [127:0] ena_data[$];
   logic [4:0]   ena_x   [$];
   logic [7:0]   ena_z   [$];
   int           done_cyc[$];
   int           drd_cyc [$];
   logic [3:0]   drd_addr[$];
   int           trd_cyc [$];
   logic [11:0]  trd_addr[$];
   logic         busy_at [0:599];
   logic         zero_ok;

   function automatic logic [24:0] mk_desc(input int z, input int x, input int y, input int b);
      return {8'(z), 5'(x), 4'(y), 8'(b)};
   endfunction

   // Cycle 1 is the first cycle after the edge that samples i_start.
   task automatic run_pass(input logic [4:0] cnt, input int ncyc, input int ign_a,
                           input int ign_b, input int rst_at);
      ena_cyc.delete(); ena_row.delete(); ena_data.delete(); ena_x.delete(); ena_z.delete();
      done_cyc.delete(); drd_cyc.delete(); drd_addr.delete(); trd_cyc.delete(); trd_addr.delete();
      zero_ok = 1'b0;
      for (int i = 0; i < 600; i++) busy_at[i] = 1'b0;
      @(negedge clk);
      bus.i_sprite_count = cnt;
      bus.i_start        = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 1; k <= ncyc; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         busy_at[k] = bus.o_busy;
         if (bus.o_ena) begin
            ena_cyc.push_back(k); ena_row.push_back(bus.o_row);
            ena_data.push_back(bus.o_texture_data);
            ena_x.push_back(bus.o_start_x); ena_z.push_back(bus.o_position_z);
         end
         if (bus.o_done) done_cyc.push_back(k);
         if (bus.o_desc_rd) begin drd_cyc.push_back(k); drd_addr.push_back(bus.o_desc_addr); end
         if (bus.o_tex_rd) begin trd_cyc.push_back(k); trd_addr.push_back(bus.o_tex_addr); end
         if (rst_at >= 0 && k == rst_at + 1)
            zero_ok = !bus.o_busy && !bus.o_done && !bus.o_ena && !bus.o_desc_rd && !bus.o_tex_rd
                      && bus.o_desc_addr == 4'd0 && bus.o_tex_addr == 12'd0
                      && bus.o_texture_data == 128'd0 && bus.o_start_x == 5'd0
                      && bus.o_position_z == 8'd0 && bus.o_row == 4'd0;
         bus.i_start = (k == ign_a || k == ign_b);
         reset       = (k == rst_at);
      end
      bus.i_start = 1'b0;
      reset       = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.i_start = 1'b0;
      bus.i_sprite_count = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
         bad++; $display("FAIL reset_busy_done: got busy=%b done=%b expected 0 0", bus.o_busy, bus.o_done);
      end
      total++;
      if (bus.o_ena !== 1'b0 || bus.o_desc_rd !== 1'b0 || bus.o_tex_rd !== 1'b0) begin
         bad++; $display("FAIL reset_strobes: got ena=%b drd=%b trd=%b expected 0 0 0",
                         bus.o_ena, bus.o_desc_rd, bus.o_tex_rd);
      end
      total++;
      if (bus.o_texture_data !== 128'd0 || bus.o_row !== 4'd0) begin
         bad++; $display("FAIL reset_bus_data: got data=%h row=%h expected 0", bus.o_texture_data, bus.o_row);
      end
      total++;
      if (bus.o_start_x !== 5'd0 || bus.o_position_z !== 8'd0 || bus.o_tex_addr !== 12'd0) begin
         bad++; $display("FAIL reset_regs: got x=%h z=%h taddr=%h expected 0",
                         bus.o_start_x, bus.o_position_z, bus.o_tex_addr);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zero_count();
      run_pass(5'd0, 6, -1, -1, -1);
      total++;
      if (done_cyc.size() != 1 || done_cyc[0] != 1) begin
         bad++; $display("FAIL zero_done: got %0d pulses (first %0d) expected 1 at cycle 1",
                         done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
      total++;
      if (busy_at[1] !== 1'b1 || busy_at[2] !== 1'b0) begin
         bad++; $display("FAIL zero_busy: got c1=%b c2=%b expected 1 0", busy_at[1], busy_at[2]);
      end
      total++;
      if (ena_cyc.size() != 0 || drd_cyc.size() != 0) begin
         bad++; $display("FAIL zero_no_activity: got ena=%0d drd=%0d expected 0 0", ena_cyc.size(), drd_cyc.size());
      end
   endtask

   task automatic test_one_sprite();
      desc_mem[0] = mk_desc(5, 20, 0, 3);
      for (int r = 0; r < 16; r++) tex_mem[{8'd3, 4'(r)}] = {16{8'(r)}};
      run_pass(5'd1, 40, -1, -1, -1);
      total++;
      if (ena_cyc.size() != 16) begin
         bad++; $display("FAIL one_ena_count: got %0d expected 16", ena_cyc.size());
      end
      for (int i = 0; i < 16 && i < ena_cyc.size(); i++) begin
         total++;
         if (ena_cyc[i] != 5 + 2*i || ena_row[i] !== 4'(i) || ena_data[i] !== {16{8'(i)}}
             || ena_x[i] !== 5'd20 || ena_z[i] !== 8'd5) begin
            bad++; $display("FAIL one_row%0d: got cyc=%0d row=%0d x=%0d z=%0d data=%h expected cyc=%0d row=%0d x=20 z=5",
                            i, ena_cyc[i], ena_row[i], ena_x[i], ena_z[i], ena_data[i], 5 + 2*i, i);
         end
      end
      for (int i = 0; i < 16 && i < trd_cyc.size(); i++) begin
         total++;
         if (trd_cyc[i] != 3 + 2*i || trd_addr[i] !== 12'h030 + 12'(i)) begin
            bad++; $display("FAIL one_tex_addr%0d: got cyc=%0d addr=%h expected cyc=%0d addr=%h",
                            i, trd_cyc[i], trd_addr[i], 3 + 2*i, 12'h030 + 12'(i));
         end
      end
      total++;
      if (drd_cyc.size() != 1 || drd_cyc[0] != 1 || drd_addr[0] !== 4'd0) begin
         bad++; $display("FAIL one_desc_rd: got %0d reads expected 1 at cycle 1 addr 0", drd_cyc.size());
      end
      total++;
      if (done_cyc.size() != 1 || done_cyc[0] != 35) begin
         bad++; $display("FAIL one_done: got %0d pulses (first %0d) expected cycle 35",
                         done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
      total++;
      if (busy_at[35] !== 1'b1 || busy_at[36] !== 1'b0) begin
         bad++; $display("FAIL one_busy_end: got c35=%b c36=%b expected 1 0", busy_at[35], busy_at[36]);
      end
   endtask

   task automatic test_clip();
      desc_mem[0] = mk_desc(12, 2, 10, 4);
      run_pass(5'd1, 40, -1, -1, -1);
      total++;
      if (ena_cyc.size() != 6) begin
         bad++; $display("FAIL clip_ena_count: got %0d expected 6", ena_cyc.size());
      end
      for (int i = 0; i < 6 && i < ena_cyc.size(); i++) begin
         total++;
         if (ena_cyc[i] != 5 + 2*i || ena_row[i] !== 4'(10 + i)
             || ena_data[i] !== {8{4'h0, 8'd4, 4'(i)}}) begin
            bad++; $display("FAIL clip_row%0d: got cyc=%0d row=%0d data=%h expected cyc=%0d row=%0d",
                            i, ena_cyc[i], ena_row[i], ena_data[i], 5 + 2*i, 10 + i);
         end
      end
      total++;
      if (done_cyc.size() != 1 || done_cyc[0] != 35) begin
         bad++; $display("FAIL clip_done: got %0d pulses (first %0d) expected cycle 35",
                         done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
   endtask

   task automatic test_back_to_back();
      desc_mem[0] = mk_desc(0, 1, 0, 5);
      desc_mem[1] = mk_desc(9, 7, 3, 6);
      desc_mem[2] = mk_desc(255, 31, 0, 7);
      run_pass(5'd3, 110, 20, 103, -1);
      total++;
      if (drd_cyc.size() != 3) begin
         bad++; $display("FAIL b2b_desc_count: got %0d expected 3", drd_cyc.size());
      end
      for (int i = 0; i < 3 && i < drd_cyc.size(); i++) begin
         total++;
         if (drd_cyc[i] != 1 + 34*i || drd_addr[i] !== 4'(i)) begin
            bad++; $display("FAIL b2b_desc%0d: got cyc=%0d addr=%0d expected cyc=%0d addr=%0d",
                            i, drd_cyc[i], drd_addr[i], 1 + 34*i, i);
         end
      end
      total++;
      if (done_cyc.size() != 1 || done_cyc[0] != 103) begin
         bad++; $display("FAIL b2b_done: got %0d pulses (first %0d) expected cycle 103",
                         done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
      total++;
      if (ena_cyc.size() != 45) begin
         bad++; $display("FAIL b2b_ena_count: got %0d expected 45", ena_cyc.size());
      end else begin
         total++;
         if (ena_cyc[16] != 39 || ena_row[16] !== 4'd3 || ena_x[16] !== 5'd7 || ena_z[16] !== 8'd9
             || ena_data[16] !== {8{4'h0, 8'd6, 4'd0}}) begin
            bad++; $display("FAIL b2b_sprite1_first: got cyc=%0d row=%0d x=%0d z=%0d expected 39 3 7 9",
                            ena_cyc[16], ena_row[16], ena_x[16], ena_z[16]);
         end
         total++;
         if (ena_cyc[28] != 63 || ena_row[28] !== 4'd15) begin
            bad++; $display("FAIL b2b_sprite1_last: got cyc=%0d row=%0d expected 63 15", ena_cyc[28], ena_row[28]);
         end
         total++;
         if (ena_cyc[44] != 103 || ena_z[44] !== 8'd255 || ena_x[44] !== 5'd31) begin
            bad++; $display("FAIL b2b_last_with_done: got cyc=%0d z=%0d x=%0d expected 103 255 31",
                            ena_cyc[44], ena_z[44], ena_x[44]);
         end
      end
      total++;
      if (busy_at[104] !== 1'b0 || busy_at[110] !== 1'b0) begin
         bad++; $display("FAIL b2b_start_ignored: got busy c104=%b c110=%b expected 0 0", busy_at[104], busy_at[110]);
      end
   endtask

   task automatic test_reset_mid();
      desc_mem[0] = mk_desc(2, 3, 0, 8);
      desc_mem[1] = mk_desc(4, 5, 0, 9);
      run_pass(5'd2, 20, -1, -1, 12);
      total++;
      if (zero_ok !== 1'b1) begin
         bad++; $display("FAIL mid_reset_outputs: got zero_ok=%b expected 1", zero_ok);
      end
      total++;
      if (done_cyc.size() != 0 || ena_cyc.size() != 4 || busy_at[20] !== 1'b0) begin
         bad++; $display("FAIL mid_reset_abort: got done=%0d ena=%0d busy20=%b expected 0 4 0",
                         done_cyc.size(), ena_cyc.size(), busy_at[20]);
      end
      run_pass(5'd2, 75, -1, -1, -1);
      total++;
      if (drd_cyc.size() != 2 || drd_cyc[0] != 1 || drd_addr[0] !== 4'd0
          || drd_cyc[1] != 35 || drd_addr[1] !== 4'd1) begin
         bad++; $display("FAIL mid_restart_desc: got %0d reads expected cycles 1,35 addrs 0,1", drd_cyc.size());
      end
      total++;
      if (done_cyc.size() != 1 || done_cyc[0] != 69 || ena_cyc.size() != 32) begin
         bad++; $display("FAIL mid_restart_pass: got done=%0d (first %0d) ena=%0d expected 1 at 69, 32",
                         done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1, ena_cyc.size());
      end else begin
         total++;
         if (ena_data[0] !== {8{4'h0, 8'd8, 4'd0}} || ena_z[0] !== 8'd2 || ena_z[16] !== 8'd4) begin
            bad++; $display("FAIL mid_restart_data: got z0=%0d z16=%0d data0=%h expected 2 4",
                            ena_z[0], ena_z[16], ena_data[0]);
         end
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 16; i++) desc_mem[i] = mk_desc(i, i, 0, 16 + i);
      run_pass(5'd31, 550, -1, -1, -1);
      total++;
      if (done_cyc.size() != 1 || done_cyc[0] != 545) begin
         bad++; $display("FAIL sat_done: got %0d pulses (first %0d) expected cycle 545",
                         done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
      end
      total++;
      if (drd_cyc.size() != 16 || drd_cyc[15] != 511 || drd_addr[15] !== 4'd15) begin
         bad++; $display("FAIL sat_desc: got %0d reads expected 16, last at 511 addr 15", drd_cyc.size());
      end
      total++;
      if (ena_cyc.size() != 256) begin
         bad++; $display("FAIL sat_ena_count: got %0d expected 256", ena_cyc.size());
      end
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) tex_mem[a] = {8{4'h0, 12'(a)}};
      for (int i = 0; i < 16; i++) desc_mem[i] = '0;
      bus.i_start = 1'b0;
      bus.i_sprite_count = '0;
      reset = 1'b1;
      test_reset();
      test_zero_count();
      test_one_sprite();
      test_clip();
      test_back_to_back();
      test_reset_mid();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
